// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector with a saturating match counter.
// The next-state table is built by constant functions when the design is elaborated.
module moore_seq_detector #(
  parameter int PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8,
  localparam int ST_W = $clog2(PATTERN_LEN + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Signal,
  input  logic             Enable,
  input  logic             Clear,
  output logic             Output,
  output logic [CNT_W-1:0] Match_Count,
  output logic             Count_Sat,
  output logic [ST_W-1:0]  State
);

  localparam int N = PATTERN_LEN;
  localparam logic [31:0] PW = 32'(PATTERN);
  localparam logic [ST_W-1:0] S0 = '0;
  localparam logic [ST_W-1:0] SN = ST_W'(PATTERN_LEN);

  if (PATTERN_LEN < 1 || PATTERN_LEN > 16) begin : g_bad_len
    $error("PATTERN_LEN must be in 1..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
    $error("CNT_W must be in 1..32");
  end

  function automatic logic [31:0] low(input logic [31:0] v,
                                      input int j);
    return v & ((32'd1 << j) - 32'd1);
  endfunction

  function automatic int border();
    int best;
    best = 0;
    for (int j = 1; j < N; j++)
      if (low(PW, j) == (PW >> (N - j)))
        best = j;
    return best;
  endfunction

  // Longest pattern prefix that is a suffix of (prefix(base) . b).
  function automatic int step_to(input int k, input logic b);
    int base;
    int best;
    logic [31:0] str;
    if (k >= N)
      base = OVERLAP ? border() : 0;
    else
      base = k;
    str = ((PW >> (N - base)) << 1) | 32'(b);
    best = 0;
    for (int j = 1; j <= N; j++)
      if (j <= base + 1 && low(str, j) == (PW >> (N - j)))
        best = j;
    return best;
  endfunction

  logic [ST_W-1:0] tab0 [2**ST_W];
  logic [ST_W-1:0] tab1 [2**ST_W];
  logic [ST_W-1:0] nxt;

  // Unreachable encodings above S_N recover to S0.
  for (genvar g = 0; g < 2**ST_W; g++) begin : g_tab
    if (g <= N) begin : g_ok
      assign tab0[g] = ST_W'(step_to(g, 1'b0));
      assign tab1[g] = ST_W'(step_to(g, 1'b1));
    end else begin : g_pad
      assign tab0[g] = S0;
      assign tab1[g] = S0;
    end
  end

  assign nxt = Signal ? tab1[State] : tab0[State];

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      State       <= S0;
      Match_Count <= '0;
    end else if (Enable) begin
      State <= nxt;
      if (nxt == SN && !Count_Sat)
        Match_Count <= Match_Count + CNT_W'(1);
    end
  end

  assign Output    = (State == SN);
  assign Count_Sat = &Match_Count;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench: four detector configurations share one stimulus stream.
// A history-based reference model predicts every output after each edge.
module tb_moore_seq_detector;

  logic Clock;
  logic Reset;
  logic Signal;
  logic Enable;
  logic Clear;

  logic       out0, out1, out2, out3;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;
  logic       sat0, sat1, sat2, sat3;
  logic [2:0] st0, st1, st2, st3;

  moore_seq_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1011),
    .OVERLAP(1'b1), .CNT_W(8)
  ) u_ov (
    .Clock(Clock), .Reset(Reset), .Signal(Signal),
    .Enable(Enable), .Clear(Clear), .Output(out0),
    .Match_Count(cnt0), .Count_Sat(sat0), .State(st0)
  );

  moore_seq_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1011),
    .OVERLAP(1'b0), .CNT_W(8)
  ) u_no (
    .Clock(Clock), .Reset(Reset), .Signal(Signal),
    .Enable(Enable), .Clear(Clear), .Output(out1),
    .Match_Count(cnt1), .Count_Sat(sat1), .State(st1)
  );

  moore_seq_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1011),
    .OVERLAP(1'b1), .CNT_W(2)
  ) u_c2 (
    .Clock(Clock), .Reset(Reset), .Signal(Signal),
    .Enable(Enable), .Clear(Clear), .Output(out2),
    .Match_Count(cnt2), .Count_Sat(sat2), .State(st2)
  );

  moore_seq_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1111),
    .OVERLAP(1'b1), .CNT_W(8)
  ) u_ones (
    .Clock(Clock), .Reset(Reset), .Signal(Signal),
    .Enable(Enable), .Clear(Clear), .Output(out3),
    .Match_Count(cnt3), .Count_Sat(sat3), .State(st3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam int PN  [4] = '{4, 4, 4, 4};
  localparam int PP  [4] = '{11, 11, 11, 15};
  localparam int POV [4] = '{1, 0, 1, 1};
  localparam int PCW [4] = '{8, 8, 2, 8};

  typedef struct {
    int st;
    int out;
    int cnt;
    int sat;
  } exp_t;

  exp_t q[$];

  int m_hist [4];
  int m_len  [4];
  int m_st   [4];
  int m_cnt  [4];

  int d_st  [4];
  int d_out [4];
  int d_cnt [4];
  int d_sat [4];

  always_comb begin
    d_st[0] = int'(st0);  d_out[0] = int'(out0);
    d_st[1] = int'(st1);  d_out[1] = int'(out1);
    d_st[2] = int'(st2);  d_out[2] = int'(out2);
    d_st[3] = int'(st3);  d_out[3] = int'(out3);
    d_cnt[0] = int'(cnt0); d_sat[0] = int'(sat0);
    d_cnt[1] = int'(cnt1); d_sat[1] = int'(sat1);
    d_cnt[2] = int'(cnt2); d_sat[2] = int'(sat2);
    d_cnt[3] = int'(cnt3); d_sat[3] = int'(sat3);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d got=%0d exp=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int mask(input int j);
    return (j >= 32) ? -1 : ((1 << j) - 1);
  endfunction

  task automatic model(input int i, input logic s,
                       input logic en, input logic clr,
                       input logic rst);
    int n;
    int mx;
    exp_t e;
    n = PN[i];
    mx = mask(PCW[i]);
    if (rst || clr) begin
      m_hist[i] = 0;
      m_len[i] = 0;
      m_st[i] = 0;
      m_cnt[i] = 0;
    end else if (en) begin
      if (m_st[i] == n && POV[i] == 0)
        m_len[i] = 0;
      m_hist[i] = (m_hist[i] << 1) | int'(s);
      if (m_len[i] < n)
        m_len[i]++;
      m_st[i] = 0;
      for (int k = 1; k <= m_len[i]; k++)
        if ((m_hist[i] & mask(k)) == (PP[i] >> (n - k)))
          m_st[i] = k;
      if (m_st[i] == n && m_cnt[i] != mx)
        m_cnt[i]++;
    end
    e.st  = m_st[i];
    e.out = (m_st[i] == n) ? 1 : 0;
    e.cnt = m_cnt[i];
    e.sat = (m_cnt[i] == mx) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic step(input logic s, input logic en,
                      input logic clr, input logic rst);
    exp_t e;
    Signal = s;
    Enable = en;
    Clear  = clr;
    Reset  = rst;
    for (int i = 0; i < 4; i++)
      model(i, s, en, clr, rst);
    @(posedge Clock);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      e = q.pop_front();
      check($sformatf("u%0d.state", i), d_st[i], e.st);
      check($sformatf("u%0d.out", i), d_out[i], e.out);
      check($sformatf("u%0d.cnt", i), d_cnt[i], e.cnt);
      check($sformatf("u%0d.sat", i), d_sat[i], e.sat);
    end
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int b = n - 1; b >= 0; b--)
      step(v[b], 1'b1, 1'b0, 1'b0);
  endtask

  int seen_hi;

  initial begin
    Reset = 1'b1;
    Signal = 1'b0;
    Enable = 1'b0;
    Clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = 0; m_len[i] = 0;
      m_st[i] = 0;   m_cnt[i] = 0;
    end

    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("rst.out", int'(out0), 0);
    check("rst.state", int'(st0), 0);

    bits(16'b1011011, 7);
    check("ov.cnt2", int'(cnt0), 2);
    check("no.cnt1", int'(cnt1), 1);
    check("ov.out_b7", int'(out0), 1);
    check("no.out_b7", int'(out1), 0);

    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++)
      bits(16'b10110, 5);
    check("c2.sat_cnt", int'(cnt2), 3);
    check("c2.sat_flag", int'(sat2), 1);

    step(1'b0, 1'b1, 1'b0, 1'b1);
    bits(16'b101, 3);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_mid.state", int'(st0), 1);
    check("rst_mid.cnt", int'(cnt0), 0);

    step(1'b0, 1'b1, 1'b0, 1'b1);
    bits(16'b101, 3);
    for (int h = 0; h < 3; h++) begin
      step(h[0], 1'b0, 1'b0, 1'b0);
      check("hold.state", int'(st0), 3);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("hold.cnt", int'(cnt0), 1);
    check("hold.out", int'(out0), 1);

    step(1'b0, 1'b1, 1'b0, 1'b1);
    bits(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr.state", int'(st0), 0);
    check("clr.cnt", int'(cnt0), 0);
    check("clr.out", int'(out0), 0);

    step(1'b0, 1'b1, 1'b0, 1'b1);
    seen_hi = 0;
    for (int b = 0; b < 6; b++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      seen_hi += int'(out3);
    end
    check("ones.cnt", int'(cnt3), 3);
    check("ones.hi_cycles", seen_hi, 3);

    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 300; r++)
      step(1'($urandom_range(1, 0)),
           ($urandom_range(7, 0) != 0),
           ($urandom_range(63, 0) == 0),
           ($urandom_range(127, 0) == 0));

    check("q.empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
